uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets four byte sources share one UART
//   transmitter. It waits in IDLE for a request and picks a winner. It
//   latches that requester's byte and index, then strobes the transmitter
//   for one cycle. It follows the transmitter's busy line through the frame
//   and inserts an idle gap before it arbitrates again.
//
//   Optional feature: define UART_ARB_TIMEOUT_EN to add a watchdog. The
//   watchdog abandons a frame whose transmitter never raises or never
//   drops busy. It pulses oErr when it fires.
//
// Parameters
//   GAP_CYCLES      idle clocks between frames (0 = no gap)
//   TIMEOUT_CYCLES  watchdog limit in clocks (only with UART_ARB_TIMEOUT_EN)
//
// Ports
//   iClk     in   system clock, rising edge
//   iRst_n   in   asynchronous active-low reset
//   iReq     in   [3:0]  level request per requester
//   idata    in   [31:0] requester k byte on idata[8k+7:8k]
//   iTxBusy  in   transmitter busy
//   oGnt     out  [3:0]  one-hot grant pulse (START only)
//   oTxEN    out  transmitter start strobe (START only)
//   odata    out  [7:0]  captured byte
//   oChan    out  [1:0]  index of requester being served
//   oBusy    out  state is not IDLE
//   oErr     out  watchdog pulse (0 without UART_ARB_TIMEOUT_EN)
module uart_tx_arbiter #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [3:0]  iReq,
  input  logic [31:0] idata,
  input  logic        iTxBusy,
  output logic [3:0]  oGnt,
  output logic        oTxEN,
  output logic [7:0]  odata,
  output logic [1:0]  oChan,
  output logic        oBusy,
  output logic        oErr
);

  localparam int NUM_REQ = 4;
  localparam int VEC_W   = 8;
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_e;

  state_e                          state_q, state_d;
  logic [VEC_W-1:0]                odata_q, odata_d;
  logic [IDX_W-1:0]                chan_q, chan_d;
  logic [IDX_W-1:0]                ptr_q, ptr_d;     // last granted requester
  logic [GAP_W-1:0]                gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0][VEC_W-1:0]   req_data;
  logic                            win_vld;
  logic [IDX_W-1:0]                win_idx;
  logic [IDX_W-1:0]                cand;
  logic                            gap_done;

  // Split the flat data bus into one byte lane per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign req_data[g] = idata[g*VEC_W +: VEC_W];
  end

  // Round-robin pick. Offsets 1..NUM_REQ from the last grant are scanned
  // from the far end inward, so the nearest asserted requester is assigned
  // last and wins. Offset NUM_REQ wraps to the last granted requester
  // itself, which gives it the lowest priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr_q + IDX_W'(i + 1);
      if (iReq[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Short gaps of 0 or 1 clock finish on the first GAP cycle.
  assign gap_done = (GAP_CYCLES <= 1) || (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
  logic            wd_expired;

  // The counter is cleared in START, so this compare fires on the
  // TIMEOUT_CYCLES-th clock spent in the two wait states.
  assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d   = state_q;
    odata_d   = odata_q;
    chan_d    = chan_q;
    ptr_d     = ptr_q;
    gap_cnt_d = gap_cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
    wd_cnt_d  = wd_cnt_q;
    err_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          odata_d = req_data[win_idx];
          chan_d  = win_idx;
          state_d = START;
        end
      end
      START: begin
        ptr_d   = chan_q;
        state_d = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      WAIT_BUSY: begin
`ifdef UART_ARB_TIMEOUT_EN
        wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        if (iTxBusy) begin
          state_d = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          state_d   = GAP;
          gap_cnt_d = '0;
          err_d     = 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
`ifdef UART_ARB_TIMEOUT_EN
        wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        if (!iTxBusy) begin
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
          gap_cnt_d = '0;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          state_d   = GAP;
          gap_cnt_d = '0;
          err_d     = 1'b1;
        end
`endif
      end
      GAP: begin
        if (gap_done) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to the last requester so the first search begins at 0.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      odata_q   <= '0;
      chan_q    <= '0;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      odata_q   <= odata_d;
      chan_q    <= chan_d;
      ptr_q     <= ptr_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign oErr = err_q;
`else
  // No watchdog: the error output is a constant 0.
  assign oErr = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // These outputs decode directly from state. Reset therefore clears them
  // as soon as it asserts.
  assign oTxEN = (state_q == START);
  assign oGnt  = (state_q == START) ? (NUM_REQ'(1) << chan_q) : '0;
  assign oBusy = (state_q != IDLE);
  assign odata = odata_q;
  assign oChan = chan_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. The stimulus pushes the expected
// {channel, byte} of each frame. The monitor pops and compares them on
// every oTxEN. A small transmitter model raises busy for BUSY_LEN clocks
// after each start strobe.
module tb_uart_tx_arbiter;

  localparam int GAP      = 4;
  localparam int TMO      = 8;
  localparam int BUSY_LEN = 10;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic [3:0]  iReq;
  logic [31:0] idata;
  logic        iTxBusy;
  logic [3:0]  oGnt;
  logic        oTxEN;
  logic [7:0]  odata;
  logic [1:0]  oChan;
  logic        oBusy;
  logic        oErr;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_gnt = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   fall_id = 0;
  int   seen_fall = 0;
  int   busy_left = 0;
  bit   tx_auto = 1'b1;
  bit   man_busy = 1'b0;
  bit   chk_gap = 1'b0;

  uart_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .idata(idata),
    .iTxBusy(iTxBusy), .oGnt(oGnt), .oTxEN(oTxEN), .odata(odata),
    .oChan(oChan), .oBusy(oBusy), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  initial forever begin
    @(posedge iClk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    q.push_back(e);
  endtask

  task automatic wait_gnt(input int target, input int budget);
    int k = 0;
    while (n_gnt < target && k < budget) begin
      @(negedge iClk);
      k++;
    end
    chk("wait_grant", 32'(n_gnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (oBusy && k < budget) begin
      @(negedge iClk);
      k++;
    end
    chk("wait_idle", 32'(oBusy), 32'd0);
  endtask

  // Transmitter model: the strobe seen on one negedge makes busy high for
  // the next BUSY_LEN negedges. Each natural fall is timestamped for the
  // gap check. A fall forced by reset is not timestamped.
  initial begin
    iTxBusy = 1'b0;
    forever begin
      @(negedge iClk);
      if (!iRst_n) begin
        busy_left = 0;
        iTxBusy   = 1'b0;
      end else if (!tx_auto) begin
        iTxBusy = man_busy;
      end else begin
        if (busy_left > 0) begin
          iTxBusy = 1'b1;
          busy_left--;
        end else begin
          if (iTxBusy) begin
            fall_cyc = cyc;
            fall_id++;
          end
          iTxBusy = 1'b0;
        end
        if (oTxEN) busy_left = BUSY_LEN;
      end
    end
  end

  // Monitor: every start strobe must match the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge iClk);
    if (iRst_n && (oTxEN || oGnt != 4'd0)) begin
      chk("strobe_and_onehot", {oTxEN, 4'($countones(oGnt))}, {1'b1, 4'd1});
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_grant: got chan %0d data %0h expected none", oChan, odata);
      end else begin
        e = q.pop_front();
        chk("grant_chan", 32'(oChan), 32'(e.ch));
        chk("grant_data", 32'(odata), 32'(e.d));
        chk("grant_onehot", 32'(oGnt), 32'(4'b0001 << e.ch));
      end
      // With requests held, busy falls, then GAP clocks pass, then one
      // IDLE clock, then START. That is GAP+2 clocks from fall to strobe.
      if (chk_gap && fall_id != seen_fall)
        chk("gap_clocks", 32'(cyc - fall_cyc), 32'(GAP + 2));
      seen_fall = fall_id;
      n_gnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected end of test");
    $fatal(1);
  end

  initial begin
    int g;
    int t0;
    int t_err;
    iRst_n = 1'b0;
    iReq   = 4'd0;
    idata  = 32'd0;
    #1;
    chk("reset_outputs", {oGnt, oTxEN, odata, oChan, oBusy, oErr}, 32'd0);
    repeat (3) @(negedge iClk);
    chk("reset_hold", {oGnt, oTxEN, odata, oChan, oBusy, oErr}, 32'd0);
    iRst_n = 1'b1;

    // All four requesting: rotation starts at 0 after reset.
    idata = 32'h4433_2211;
    push(2'd0, 8'h11); push(2'd1, 8'h22); push(2'd2, 8'h33);
    push(2'd3, 8'h44); push(2'd0, 8'h11);
    chk_gap = 1'b1;
    iReq = 4'hF;
    wait_gnt(5, 400);
    iReq = 4'd0;
    chk_gap = 1'b0;
    wait_idle(100);

    // Single request, one-clock latency to the strobe.
    iReq  = 4'b0100;
    idata = 32'h00A5_0000;
    push(2'd2, 8'hA5);
    @(negedge iClk);
    chk("single_latency", 32'(oTxEN), 32'd1);
    iReq = 4'd0;
    wait_idle(100);

    // Serve requester 3, then 0 and 3 contend: 0 goes first.
    g = n_gnt;
    iReq  = 4'b1000;
    idata = 32'h5C00_0000;
    push(2'd3, 8'h5C);
    wait_gnt(g + 1, 50);
    iReq = 4'd0;
    wait_idle(100);
    iReq  = 4'b1001;
    idata = 32'hC300_00C0;
    push(2'd0, 8'hC0); push(2'd3, 8'hC3);
    wait_gnt(g + 3, 100);
    iReq = 4'd0;
    wait_idle(100);

    // Captured byte holds while the bus changes mid-frame.
    g = n_gnt;
    iReq  = 4'b0010;
    idata = 32'h0000_7700;
    push(2'd1, 8'h77);
    wait_gnt(g + 1, 50);
    iReq = 4'd0;
    for (int k = 0; k < 60 && oBusy; k++) begin
      idata = idata + 32'h0101_0101;
      @(negedge iClk);
      if (oBusy) chk("odata_stable", {22'd0, oChan, odata}, {22'd0, 2'd1, 8'h77});
    end
    wait_idle(100);

    // Transmitter never goes busy.
    tx_auto  = 1'b0;
    man_busy = 1'b0;
    iReq  = 4'b0001;
    idata = 32'h0000_003C;
    push(2'd0, 8'h3C);
    @(negedge iClk);
    chk("stall_strobe", 32'(oTxEN), 32'd1);
    iReq = 4'd0;
    t0 = cyc;
`ifdef UART_ARB_TIMEOUT_EN
    t_err = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge iClk);
      if (oErr) begin
        t_err = cyc;
        break;
      end
    end
    // START strobe, then TMO clocks in WAIT_BUSY, then the pulse.
    chk("timeout_delay", 32'(t_err - t0), 32'(TMO + 1));
    @(negedge iClk);
    chk("err_pulse_width", 32'(oErr), 32'd0);
    wait_idle(50);
`else
    t_err = 0;
    repeat (40) @(negedge iClk);
    chk("stall_busy", 32'(oBusy), 32'd1);
    chk("stall_no_err", 32'(oErr), 32'd0);
    chk("stall_no_strobe", 32'(oTxEN), 32'(t_err));
    man_busy = 1'b1;
    repeat (3) @(negedge iClk);
    man_busy = 1'b0;
    wait_idle(50);
`endif
    tx_auto = 1'b1;

    // Reset during WAIT_DONE abandons the frame; 1 wins after release.
    g = n_gnt;
    iReq  = 4'b0100;
    idata = 32'h0099_0000;
    push(2'd2, 8'h99);
    wait_gnt(g + 1, 50);
    iReq = 4'd0;
    for (int k = 0; k < 20 && !iTxBusy; k++) @(negedge iClk);
    repeat (3) @(negedge iClk);
    chk("midframe_busy", 32'(oBusy), 32'd1);
    idata  = 32'hB300_B100;
    iReq   = 4'b1010;
    iRst_n = 1'b0;
    #1;
    chk("reset_midframe", {oGnt, oTxEN, odata, oChan, oBusy, oErr}, 32'd0);
    push(2'd1, 8'hB1);
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    wait_gnt(g + 2, 50);
    iReq = 4'd0;
    wait_idle(100);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
